dmem_dump_reader: RTL
=====================

Name: dmem_dump_reader

Overview:
Readback engine for the CPU data memory, the read-side counterpart of the instruction/data load port. After a program has run, it sweeps a contiguous window of data-memory words through a synchronous read port. Each word is emitted with its address on a valid/ready stream, so a bench or debug host can inspect results without poking hierarchical paths. It sits beside the data memory and shares its 10-bit word address space.

Parameters:
ADDR_W, 10, word-address width of data memory (1024 words)
DATA_W, 32, data word width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a dump; sampled only in IDLE
base_addr  input  ADDR_W  first word address, captured on accepted start
word_count  input  ADDR_W+1  number of words to dump (0..1024), captured on accepted start
mem_re  output  1  data-memory read enable
mem_addr  output  ADDR_W  data-memory read address
mem_rdata  input  DATA_W  read data, valid exactly 1 cycle after mem_re
dout  output  DATA_W  stream data
dout_addr  output  ADDR_W  address of word on dout
dout_valid  output  1  stream valid
dout_ready  input  1  stream ready from consumer
dout_last  output  1  marks final beat of the dump
busy  output  1  high from accepted start until return to IDLE
done  output  1  one-cycle pulse when the dump completes

Behaviour:
- Reset (async, immediate):
  - All outputs 0; FSM to IDLE.
  - Internal address, remaining count and holding registers cleared.
  - Reset mid-dump aborts with no further beats and no done pulse.
- States: IDLE, READ, WAIT, SEND, FINISH.
- IDLE:
  - On start=1: capture base_addr and word_count, then set busy=1.
  - If word_count=0, go to FINISH. Otherwise go to READ.
- READ: mem_re=1 and mem_addr=current address for exactly one cycle; go to WAIT.
- WAIT: capture mem_rdata into the dout holding register; go to SEND.
- SEND:
  - dout_valid=1. dout, dout_addr and dout_last stay stable until the handshake.
  - Handshake occurs on a cycle with dout_valid=1 and dout_ready=1.
  - On handshake: address = address+1, wrapping modulo 2^ADDR_W (1023 -> 0); remaining count decrements.
  - If remaining count reaches 0, go to FINISH; otherwise go to READ.
  - dout_valid must never drop without a handshake.
- FINISH: done=1 for one cycle, busy=0 next cycle; return to IDLE.
- Throughput: 3 cycles per word when dout_ready is held high. Latency from start to first dout_valid is 3 cycles.
- dout_last: high during SEND of the final data beat (no CHECKSUM build).
- start while busy: ignored, with no effect on the captured window.
- mem_re is low in every state except READ. The block never writes memory.
- word_count > 1024 is not possible by width. word_count=1024 dumps the whole memory, wrapping from base_addr.

Optional Feature:
- DUMP_CHECKSUM_EN defined:
  - After the last data beat, one extra SEND beat is emitted.
  - On that beat, dout = 32-bit wrap-around sum of all dumped words, dout_addr = base_addr.
  - dout_last moves to this checksum beat only.
  - word_count=0 emits a single checksum beat of 0 before FINISH.
- DUMP_CHECKSUM_EN undefined: no extra beat; behaviour exactly as above.

Test Plan:
- Preload M[0]=10, M[15]=10. Start with base=0, count=16, ready tied high:
  - 16 beats, addresses 0..15.
  - dout=10 at addresses 0 and 15, 0 elsewhere.
  - dout_last on address 15; done one cycle after the final handshake; first valid 3 cycles after start.
- Same dump with dout_ready toggled 1-0-0-1 pseudo-randomly:
  - dout, dout_addr and dout_valid stable while ready=0.
  - No beat lost or duplicated.
- Base=1022, count=4, M[1022..1023]=7,8 and M[0..1]=9,10:
  - Beats (1022,7), (1023,8), (0,9), (1,10).
- count=0: done pulse with zero beats, mem_re never asserted. With DUMP_CHECKSUM_EN: one beat dout=0 with dout_last=1.
- Assert rst during SEND of the 3rd beat:
  - All outputs 0 immediately, no done pulse.
  - A new start after reset dumps correctly from its new base.
- With DUMP_CHECKSUM_EN, base=0, count=3, M[0..2]=0xFFFFFFFF,2,3:
  - 4 beats; final dout=0x00000004 with dout_last=1.

Source files
------------

// File: rtl/dmem_dump_reader.sv
// Purpose : sweeps a window of data-memory words out on a valid/ready stream, each word tagged with its address.
// Latency : 3 cycles from accepted start to first dout_valid; 3 cycles per word with dout_ready held high.
// Backpress: dout_valid/dout/dout_addr/dout_last hold until dout_ready; no further memory read is issued while stalled.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   start/base_addr/word_count dump request; window captured only when accepted in IDLE
//   mem_re/mem_addr/mem_rdata synchronous read port of the data memory (data one cycle after mem_re)
//   dout/dout_addr/dout_valid/dout_ready/dout_last  output stream
//   busy/done                 status: busy from accepted start to IDLE, done pulses once at completion
//
// Build option: DUMP_CHECKSUM_EN appends one beat carrying the 32-bit wrap-around
// sum of all dumped words (dout_addr = base_addr); dout_last then marks only that beat.
module dmem_dump_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] dout_addr,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WAIT   = 3'd2,
    SEND   = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic [DATA_W-1:0] data_q;
  logic              hs;
  logic              final_data;

`ifdef DUMP_CHECKSUM_EN
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] sum_q;
  logic              ck_beat_q;   // current SEND beat is the checksum beat
`endif

  assign hs         = (state == SEND) && dout_ready;
  // Beat in SEND is the last data word of the window.
  assign final_data = (remaining_q == (ADDR_W+1)'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (word_count == '0) begin
`ifdef DUMP_CHECKSUM_EN
            state_nxt = SEND;
`else
            state_nxt = FINISH;
`endif
          end else begin
            state_nxt = READ;
          end
        end
      end
      READ: state_nxt = WAIT;
      WAIT: state_nxt = SEND;
      SEND: begin
        if (hs) begin
`ifdef DUMP_CHECKSUM_EN
          if (ck_beat_q)       state_nxt = FINISH;
          else if (final_data) state_nxt = SEND;   // straight to checksum beat
          else                 state_nxt = READ;
`else
          if (final_data) state_nxt = FINISH;
          else            state_nxt = READ;
`endif
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: address, remaining count, holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
`ifdef DUMP_CHECKSUM_EN
      base_q      <= '0;
      sum_q       <= '0;
      ck_beat_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q      <= base_addr;
            remaining_q <= word_count;
            data_q      <= '0;
`ifdef DUMP_CHECKSUM_EN
            base_q      <= base_addr;
            sum_q       <= '0;
            ck_beat_q   <= (word_count == '0);
`endif
          end
        end
        WAIT: begin
          data_q <= mem_rdata;
`ifdef DUMP_CHECKSUM_EN
          sum_q  <= sum_q + mem_rdata;
`endif
        end
        SEND: begin
          if (hs) begin
`ifdef DUMP_CHECKSUM_EN
            if (ck_beat_q) begin
              ck_beat_q <= 1'b0;
            end else begin
              addr_q      <= addr_q + 1'b1;
              remaining_q <= remaining_q - 1'b1;
              if (final_data) begin
                ck_beat_q <= 1'b1;
                data_q    <= sum_q;   // sum already includes the last word
              end
            end
`else
            addr_q      <= addr_q + 1'b1;   // wraps naturally at 2^ADDR_W
            remaining_q <= remaining_q - 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs (all derived from reset registers, so they read 0 during reset)
  always_comb begin
    mem_re     = (state == READ);
    mem_addr   = addr_q;
    dout       = data_q;
    dout_valid = (state == SEND);
    busy       = (state != IDLE);
    done       = (state == FINISH);
`ifdef DUMP_CHECKSUM_EN
    dout_addr  = ck_beat_q ? base_q : addr_q;
    dout_last  = (state == SEND) && ck_beat_q;
`else
    dout_addr  = addr_q;
    dout_last  = (state == SEND) && final_data;
`endif
  end

endmodule
